hex_debug_pager: RTL and testbench
==================================

# hex_debug_pager

Parametrised, registered debug-display pager for the board's HEX displays. It replaces the fixed 2-bit switch mux with a generic N-page selector and adds:
- debounced manual page selection;
- an auto-rotate mode;
- a freeze/hold function;
- per-digit blanking.

It sits at the top level between the debug nibble buses (FSM states, lever/servo values, stepper position) and the HEX5..HEX0 pins.

## Interface
Parameters:
- NUM_PAGES, 4: number of selectable pages, 2..16.
- DIGITS, 6: seven-segment digits per page, 1..8.
- DWELL_CYCLES, 50_000_000: clock cycles per page in auto mode, at least 2.
- DEBOUNCE_CYCLES, 500_000: cycles that the synchronised selection must stay stable before it is accepted, at least 1.
- SELW = max(1, clog2(NUM_PAGES)), a derived local width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- page_data  in  NUM_PAGES*DIGITS*4  hex nibbles.
  - Page p, digit d is at bits [(p*DIGITS+d)*4 +: 4].
  - Digit 0 is the rightmost display.
- page_blank  in  NUM_PAGES*DIGITS  bit p*DIGITS+d = 1 blanks that digit.
- sel  in  SELW  manual page select from the switches; asynchronous.
- auto_mode  in  1  1 = rotate pages, 0 = manual; asynchronous.
- freeze  in  1  1 = hold the current display; asynchronous.
- hex  out  DIGITS*7  active-low segments {g,f,e,d,c,b,a}; digit d is at [d*7 +: 7].
- page_idx  out  SELW  page currently displayed.
- page_change  out  1  one-cycle pulse each time page_idx changes.

## Operation
- **Input synchronisation.** sel, auto_mode and freeze each pass through a 2-flop synchroniser. All behaviour below uses the synchronised values (sel_s, auto_s, frz_s).
- **Segment encoding.**
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000.
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
  - Blank → 1111111. Dash → 0111111.
- **Manual mode** (auto_s=0, frz_s=0):
  - A debounce counter clears whenever sel_s changes or sel_s equals page_idx. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1: page_idx ← sel_s, page_change=1, and the counter clears.
  - If sel_s ≥ NUM_PAGES, page_idx is not updated. Every digit then shows dash (out_of_range flag) until a valid sel is accepted.
- **Auto mode** (auto_s=1, frz_s=0):
  - The dwell counter runs 0..DWELL_CYCLES-1.
  - On the terminal count, page_idx ← (page_idx == NUM_PAGES-1) ? 0 : page_idx+1, page_change=1, and the counter clears.
  - The out_of_range flag clears on entry to auto mode.
  - The 0→1 edge of auto_s clears the dwell counter; page_idx is unchanged.
  - The 1→0 edge of auto_s clears the debounce counter. Manual selection then resumes from the current page_idx.
- **Freeze** (frz_s=1):
  - The hex register holds.
  - page_idx holds.
  - The dwell counter pauses at its current value.
  - The debounce counter clears.
  - page_change=0.
  - Freeze has priority over every other event in the same cycle.
- **Display register.** When not frozen, the hex register loads each cycle: dash if out_of_range; else blank if page_blank is set; else the encoded nibble of page page_idx. Live page_data changes are tracked each cycle.
- **Arithmetic.** Counters are sized clog2(max(DWELL_CYCLES, DEBOUNCE_CYCLES)) bits, with no overflow. page_idx never holds a value ≥ NUM_PAGES.

## Timing
- **Reset values:** hex = all 1s (all blank), page_idx = 0, page_change = 0, out_of_range = 0, both counters = 0, synchroniser flops = 0.
- **Input latency:** 2 cycles of synchronisation before any input takes effect.
- **Manual change latency:** 2 (sync) + DEBOUNCE_CYCLES cycles from a stable sel edge to the page_idx update. page_change is asserted in the same cycle as the update.
- **Display latency:** hex reflects the new page_idx, and any page_data/page_blank change, 1 cycle later (registered).
- **Auto rotation:** page_idx advances exactly every DWELL_CYCLES cycles when freeze is not asserted; a frozen interval extends the period by its length.
- **Mid-operation reset:** asynchronous; outputs take their reset values immediately, independent of the clock.

## Test plan
Bench parameters for all scenarios: NUM_PAGES=3, DIGITS=2, DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.

- **Reset and static page:** reset, then page 0 data = 0x00A5 → hex = {0001000, 0010010} 1 cycle after reset release; page_idx=0; page_change never pulses.
- **Debounced switch:** sel 0→2 held → page_idx=2 and one page_change pulse exactly 6 cycles after the edge. A sel glitch 0→1→0 lasting 3 cycles → no change.
- **Out of range:** sel=3 held for 10 cycles → page_idx stays at its previous value; both digits show 0111111. Then sel=1 → page 1 shown.
- **Auto rotate and wrap:** auto_mode=1 → page_idx sequence 0,1,2,0 at 8-cycle intervals, with one page_change per step.
- **Freeze priority:** freeze asserted on the same synchronised cycle as the dwell terminal count → no advance and hex holds while page_data changes. After freeze is released, the advance occurs on the next cycle.
- **Blank plus async reset:** page_blank bit 1 set → digit 1 = 1111111. Reset asserted mid-rotation → hex all 1s and page_idx=0 immediately.

Source files
------------

// File: rtl/hex_debug_pager.sv
// Debug pager for the HEX displays: picks one of NUM_PAGES nibble pages by debounced
// switch or auto-rotation, with freeze and per-digit blanking, and registers the segments.
module hex_debug_pager #(
   parameter int NUM_PAGES       = 4,
   parameter int DIGITS          = 6,
   parameter int DWELL_CYCLES    = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000,
   localparam int SELW = (NUM_PAGES > 2) ? $clog2(NUM_PAGES) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_PAGES*DIGITS*4-1:0] page_data,
   input  logic [NUM_PAGES*DIGITS-1:0]   page_blank,
   input  logic [SELW-1:0]               sel,
   input  logic                          auto_mode,
   input  logic                          freeze,
   output logic [DIGITS*7-1:0]           hex,
   output logic [SELW-1:0]               page_idx,
   output logic                          page_change
);

   localparam int CMAX = (DWELL_CYCLES > DEBOUNCE_CYCLES) ? DWELL_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW   = $clog2(CMAX);
   localparam logic [CW-1:0]   DW_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SELW-1:0] LAST_PG = SELW'(NUM_PAGES - 1);
   localparam logic [SELW:0]   NP_L    = (SELW + 1)'(NUM_PAGES);
   localparam logic [6:0]      SEG_DASH  = 7'b0111111;
   localparam logic [6:0]      SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         4'hF: seg7 = 7'b0001110;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   logic [SELW-1:0]   sel_m_q, sel_s_q;
   logic              auto_m_q, auto_s_q, frz_m_q, frz_s_q;
   logic [SELW-1:0]   page_idx_q, page_idx_d;
   logic              page_change_q, page_change_d;
   logic              oor_q, oor_d;
   logic [CW-1:0]     deb_q, deb_d, dwell_q, dwell_d;
   logic [DIGITS*7-1:0] hex_q;
   wire  [DIGITS*7-1:0] hex_d;
   wire  [3:0]        nib_s [NUM_PAGES][DIGITS];
   wire               blk_s [NUM_PAGES][DIGITS];
   logic              sel_ok_s;

   for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
      for (genvar d = 0; d < DIGITS; d++) begin : g_dig
         assign nib_s[p][d] = page_data[(p*DIGITS+d)*4 +: 4];
         assign blk_s[p][d] = page_blank[p*DIGITS+d];
      end
   end

   // Dash wins over blank, blank over data; frozen digits keep their last value.
   for (genvar d = 0; d < DIGITS; d++) begin : g_hex
      assign hex_d[d*7 +: 7] = frz_s_q                ? hex_q[d*7 +: 7] :
                               oor_q                  ? SEG_DASH :
                               blk_s[page_idx_q][d]   ? SEG_BLANK :
                                                        seg7(nib_s[page_idx_q][d]);
   end

   // Page selection, debounce/dwell counters and the out-of-range flag.
   always_comb begin
      page_idx_d    = page_idx_q;
      page_change_d = 1'b0;
      oor_d         = oor_q;
      deb_d         = deb_q;
      dwell_d       = dwell_q;
      sel_ok_s      = ({1'b0, sel_s_q} < NP_L);
      if (frz_s_q) begin
         deb_d = '0;
      end else if (auto_s_q) begin
         deb_d = '0;
         oor_d = 1'b0;
         if (dwell_q == DW_LAST) begin
            dwell_d       = '0;
            page_change_d = 1'b1;
            page_idx_d    = (page_idx_q == LAST_PG) ? '0 : page_idx_q + SELW'(1);
         end else begin
            dwell_d = dwell_q + CW'(1);
         end
      end else begin
         // Holding dwell at zero in manual mode makes every auto entry start a full period.
         dwell_d = '0;
         if ((sel_m_q != sel_s_q) || (sel_s_q == page_idx_q)) begin
            deb_d = '0;
         end else if (deb_q == DB_LAST) begin
            deb_d = '0;
            if (sel_ok_s) begin
               page_idx_d    = sel_s_q;
               page_change_d = 1'b1;
               oor_d         = 1'b0;
            end else begin
               oor_d = 1'b1;
            end
         end else begin
            deb_d = deb_q + CW'(1);
         end
      end
   end

   // Synchronisers and all state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_m_q       <= '0;
         sel_s_q       <= '0;
         auto_m_q      <= 1'b0;
         auto_s_q      <= 1'b0;
         frz_m_q       <= 1'b0;
         frz_s_q       <= 1'b0;
         page_idx_q    <= '0;
         page_change_q <= 1'b0;
         oor_q         <= 1'b0;
         deb_q         <= '0;
         dwell_q       <= '0;
         hex_q         <= '1;
      end else begin
         sel_m_q       <= sel;
         sel_s_q       <= sel_m_q;
         auto_m_q      <= auto_mode;
         auto_s_q      <= auto_m_q;
         frz_m_q       <= freeze;
         frz_s_q       <= frz_m_q;
         page_idx_q    <= page_idx_d;
         page_change_q <= page_change_d;
         oor_q         <= oor_d;
         deb_q         <= deb_d;
         dwell_q       <= dwell_d;
         hex_q         <= hex_d;
      end
   end

   assign hex         = hex_q;
   assign page_idx    = page_idx_q;
   assign page_change = page_change_q;

endmodule

// File: tb/tb_hex_debug_pager.sv
// Bench for hex_debug_pager with 3 pages of 2 digits, dwell 8, debounce 4.
module tb_hex_debug_pager;

   logic        clock = 1'b0;
   logic        reset;
   logic [23:0] page_data;
   logic [5:0]  page_blank;
   logic [1:0]  sel;
   logic        auto_mode, freeze;
   logic [13:0] hex;
   logic [1:0]  page_idx;
   logic        page_change;

   hex_debug_pager #(.NUM_PAGES(3), .DIGITS(2), .DWELL_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .page_data(page_data), .page_blank(page_blank),
      .sel(sel), .auto_mode(auto_mode), .freeze(freeze),
      .hex(hex), .page_idx(page_idx), .page_change(page_change)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [5:0]  blank;
      logic [23:0] data;
      int          n;
      logic [1:0]  idx;
      logic [13:0] hex;
      logic        chg;
   } vec_t;

   typedef struct {
      string       name;
      logic [1:0]  idx;
      logic [13:0] hex;
      logic        chg;
   } exp_t;

   localparam logic [23:0] D0 = 24'hB419A5;
   localparam logic [23:0] D1 = 24'hB46EA5;
   localparam logic [23:0] D2 = 24'hB419C3;
   localparam logic [13:0] DASH2  = {7'b0111111, 7'b0111111};
   localparam logic [13:0] BLANK2 = 14'h3FFF;

   logic [6:0] seg_t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   vec_t vecs [15];
   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   pulse_cnt = 0;

   function automatic logic [13:0] pg(input logic [23:0] d, input int p);
      logic [3:0] lo, hi;
      lo = d[p*8 +: 4];
      hi = d[p*8+4 +: 4];
      return {seg_t[hi], seg_t[lo]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
      if (page_change === 1'b1) pulse_cnt++;
   endtask

   task automatic expect_push(input string name, input logic [1:0] idx,
                              input logic [13:0] hx, input logic chg);
      exp_t e;
      e.name = name; e.idx = idx; e.hex = hx; e.chg = chg;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (page_idx !== e.idx || hex !== e.hex || page_change !== e.chg) begin
         n_err++;
         $display("FAIL %s: got idx=%0d hex=%b chg=%b, want idx=%0d hex=%b chg=%b",
                  e.name, page_idx, hex, page_change, e.idx, e.hex, e.chg);
      end
   endtask

   task automatic check(input string name, input logic [1:0] idx,
                        input logic [13:0] hx, input logic chg);
      expect_push(name, idx, hx, chg);
      compare();
   endtask

   initial begin
      vecs[0]  = '{"static",       2'd0, 6'd0,      D0, 1,  2'd0, pg(D0,0), 1'b0};
      vecs[1]  = '{"static hold",  2'd0, 6'd0,      D0, 3,  2'd0, pg(D0,0), 1'b0};
      vecs[2]  = '{"deb wait",     2'd2, 6'd0,      D0, 5,  2'd0, pg(D0,0), 1'b0};
      vecs[3]  = '{"deb switch",   2'd2, 6'd0,      D0, 1,  2'd2, pg(D0,0), 1'b1};
      vecs[4]  = '{"deb display",  2'd2, 6'd0,      D0, 1,  2'd2, pg(D0,2), 1'b0};
      vecs[5]  = '{"glitch on",    2'd1, 6'd0,      D0, 3,  2'd2, pg(D0,2), 1'b0};
      vecs[6]  = '{"glitch off",   2'd2, 6'd0,      D0, 10, 2'd2, pg(D0,2), 1'b0};
      vecs[7]  = '{"oor dash",     2'd3, 6'd0,      D0, 7,  2'd2, DASH2,    1'b0};
      vecs[8]  = '{"oor hold",     2'd3, 6'd0,      D0, 3,  2'd2, DASH2,    1'b0};
      vecs[9]  = '{"oor recover",  2'd1, 6'd0,      D0, 6,  2'd1, DASH2,    1'b1};
      vecs[10] = '{"page1 shown",  2'd1, 6'd0,      D0, 1,  2'd1, pg(D0,1), 1'b0};
      vecs[11] = '{"blank d1",     2'd1, 6'b001000, D0, 1,  2'd1, {7'b1111111, seg_t[9]}, 1'b0};
      vecs[12] = '{"live data",    2'd1, 6'd0,      D1, 1,  2'd1, pg(D1,1), 1'b0};
      vecs[13] = '{"back to 0",    2'd0, 6'd0,      D0, 6,  2'd0, pg(D0,1), 1'b1};
      vecs[14] = '{"page0 again",  2'd0, 6'd0,      D0, 1,  2'd0, pg(D0,0), 1'b0};

      reset = 1'b1; page_data = D0; page_blank = 6'd0; sel = 2'd0;
      auto_mode = 1'b0; freeze = 1'b0;
      repeat (3) tick();
      check("reset", 2'd0, BLANK2, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         sel = vecs[i].sel; page_blank = vecs[i].blank; page_data = vecs[i].data;
         expect_push(vecs[i].name, vecs[i].idx, vecs[i].hex, vecs[i].chg);
         repeat (vecs[i].n) tick();
         compare();
      end

      // Auto rotation, wrap and freeze on the terminal-count cycle.
      auto_mode = 1'b1;
      for (int e = 1; e <= 42; e++) begin
         tick();
         if (e == 9)  check("auto e9",    2'd0, pg(D0,0), 1'b0);
         if (e == 10) check("auto step1", 2'd1, pg(D0,0), 1'b1);
         if (e == 11) check("auto disp1", 2'd1, pg(D0,1), 1'b0);
         if (e == 17) check("auto e17",   2'd1, pg(D0,1), 1'b0);
         if (e == 18) check("auto step2", 2'd2, pg(D0,1), 1'b1);
         if (e == 26) check("auto wrap",  2'd0, pg(D0,2), 1'b1);
         if (e == 33) check("pre freeze", 2'd0, pg(D0,0), 1'b0);
         if (e == 34) check("frz no adv", 2'd0, pg(D0,0), 1'b0);
         if (e == 37) check("frz hold",   2'd0, pg(D0,0), 1'b0);
         if (e == 38) check("frz resume", 2'd1, pg(D2,0), 1'b1);
         if (e == 39) check("post frz",   2'd1, pg(D2,1), 1'b0);
         if (e == 31) freeze = 1'b1;
         if (e == 34) page_data = D2;
         if (e == 35) freeze = 1'b0;
      end

      n_vec++;
      if (pulse_cnt != 7) begin
         n_err++;
         $display("FAIL pulse count: got %0d, want 7", pulse_cnt);
      end

      #3 reset = 1'b1;
      #1 check("async reset", 2'd0, BLANK2, 1'b0);
      repeat (2) tick();
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
